// File: rtl/trap_entry_seq.sv
// Trap entry/return sequencer: writes xEPC/xCAUSE/xTVAL over the shared CSR port,
// pulses the status update, then redirects fetch and switches privilege.
module trap_entry_seq #(
    parameter int unsigned XLEN     = 64,
    parameter logic [11:0] A_MEPC   = 12'h341,
    parameter logic [11:0] A_MCAUSE = 12'h342,
    parameter logic [11:0] A_MTVAL  = 12'h343,
    parameter logic [11:0] A_SEPC   = 12'h141,
    parameter logic [11:0] A_SCAUSE = 12'h142,
    parameter logic [11:0] A_STVAL  = 12'h143
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      priv,
    input  logic            exc_target_m,
    input  logic            exc_target_s,
    input  logic [XLEN-1:0] exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret,
    input  logic            sret,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] stvec,
    input  logic [XLEN-1:0] mepc,
    input  logic [XLEN-1:0] sepc,
    input  logic [1:0]      mpp,
    input  logic            spp,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            stat_trap_m,
    output logic            stat_trap_s,
    output logic            stat_ret_m,
    output logic            stat_ret_s,
    output logic            redirect,
    output logic [XLEN-1:0] pc_target,
    output logic            priv_we,
    output logic [3:0]      priv_next,
    output logic            stall
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_EPC,
        ST_W_CAUSE,
        ST_W_TVAL,
        ST_W_STAT,
        ST_REDIR,
        ST_RET
    } state_t;

    localparam logic [3:0]      PRIV_M     = 4'b1000;
    localparam logic [3:0]      PRIV_S     = 4'b0010;
    localparam logic [3:0]      PRIV_U     = 4'b0001;
    localparam logic [XLEN-1:0] TVEC_MASK  = {{(XLEN-2){1'b1}}, 2'b00};

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_tgt_m;     // exception: target is M; return: mret (vs sret)
    logic [XLEN-1:0]   r_cause;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_tval;
    logic [3:0]        r_priv;

    logic              w_take_exc;
    logic              w_acc_mret;
    logic              w_acc_sret;
    logic              w_accept;

    // A ret from too low a privilege is dropped here; the decoder raises ill_ins for it.
    assign w_take_exc = exc_target_m | exc_target_s;
    assign w_acc_mret = ~w_take_exc & mret & (|(priv & 4'b1000));
    assign w_acc_sret = ~w_take_exc & ~mret & sret & (|(priv & 4'b1010));
    assign w_accept   = ~rst & (r_state == ST_IDLE) & (w_take_exc | w_acc_mret | w_acc_sret);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_tgt_m <= 1'b0;
            r_cause <= '0;
            r_pc    <= '0;
            r_tval  <= '0;
            r_priv  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_tgt_m <= exc_target_m | (~exc_target_s & w_acc_mret);
                r_cause <= exc_cause;
                r_pc    <= exc_pc;
                r_tval  <= exc_tval;
                r_priv  <= priv;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        csr_we      = 1'b0;
        csr_waddr   = '0;
        csr_wdata   = '0;
        stat_trap_m = 1'b0;
        stat_trap_s = 1'b0;
        stat_ret_m  = 1'b0;
        stat_ret_s  = 1'b0;
        redirect    = 1'b0;
        pc_target   = '0;
        priv_we     = 1'b0;
        priv_next   = '0;
        stall       = (r_state != ST_IDLE) | w_accept;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = w_take_exc ? ST_W_EPC : ST_RET;
            end
            ST_W_EPC: begin
                csr_we      = 1'b1;
                csr_waddr   = r_tgt_m ? A_MEPC : A_SEPC;
                csr_wdata   = r_pc;
                w_state_nxt = ST_W_CAUSE;
            end
            ST_W_CAUSE: begin
                csr_we      = 1'b1;
                csr_waddr   = r_tgt_m ? A_MCAUSE : A_SCAUSE;
                csr_wdata   = r_cause;
                w_state_nxt = ST_W_TVAL;
            end
            ST_W_TVAL: begin
                csr_we      = 1'b1;
                csr_waddr   = r_tgt_m ? A_MTVAL : A_STVAL;
                csr_wdata   = r_tval;
                w_state_nxt = ST_W_STAT;
            end
            ST_W_STAT: begin
                stat_trap_m = r_tgt_m;
                stat_trap_s = ~r_tgt_m;
                w_state_nxt = ST_REDIR;
            end
            ST_REDIR: begin
                redirect    = 1'b1;
                priv_we     = 1'b1;
                pc_target   = (r_tgt_m ? mtvec : stvec) & TVEC_MASK;
                priv_next   = r_tgt_m ? PRIV_M : PRIV_S;
                w_state_nxt = ST_IDLE;
            end
            ST_RET: begin
                redirect = 1'b1;
                priv_we  = 1'b1;
                if (r_tgt_m) begin
                    stat_ret_m = 1'b1;
                    pc_target  = mepc;
                    case (mpp)
                        2'b11:   priv_next = PRIV_M;
                        2'b01:   priv_next = PRIV_S;
                        default: priv_next = PRIV_U;
                    endcase
                end else begin
                    stat_ret_s = 1'b1;
                    pc_target  = sepc;
                    priv_next  = spp ? PRIV_S : PRIV_U;
                end
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_trap_entry_seq.sv
// Scoreboard bench for trap_entry_seq: directed trap/return sequences push
// cycle-stamped expected outputs; a negedge monitor pops and compares.
module tb_trap_entry_seq;

    localparam int XL = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    priv;
    logic          exc_target_m, exc_target_s;
    logic [XL-1:0] exc_cause, exc_pc, exc_tval;
    logic          mret, sret;
    logic [XL-1:0] mtvec, stvec, mepc, sepc;
    logic [1:0]    mpp;
    logic          spp;
    logic          csr_we;
    logic [11:0]   csr_waddr;
    logic [XL-1:0] csr_wdata;
    logic          stat_trap_m, stat_trap_s, stat_ret_m, stat_ret_s;
    logic          redirect;
    logic [XL-1:0] pc_target;
    logic          priv_we;
    logic [3:0]    priv_next;
    logic          stall;

    trap_entry_seq #(.XLEN(XL)) dut (
        .clk(clk), .rst(rst), .priv(priv),
        .exc_target_m(exc_target_m), .exc_target_s(exc_target_s),
        .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .mret(mret), .sret(sret), .mtvec(mtvec), .stvec(stvec),
        .mepc(mepc), .sepc(sepc), .mpp(mpp), .spp(spp),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .stat_trap_m(stat_trap_m), .stat_trap_s(stat_trap_s),
        .stat_ret_m(stat_ret_m), .stat_ret_s(stat_ret_s),
        .redirect(redirect), .pc_target(pc_target),
        .priv_we(priv_we), .priv_next(priv_next), .stall(stall)
    );

    always #5 clk = ~clk;

    // stat field order: {trap_m, trap_s, ret_m, ret_s}
    typedef struct packed {
        logic          we;
        logic [11:0]   addr;
        logic [XL-1:0] wdata;
        logic [3:0]    stat;
        logic          redir;
        logic [XL-1:0] pc;
        logic          pwe;
        logic [3:0]    pn;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t o;
    } item_t;

    item_t sb[$];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    st_from = 1;
    int    st_to = 0;
    bit    mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t mk(input logic we, input logic [11:0] a, input logic [XL-1:0] d,
                                input logic [3:0] st, input logic rd, input logic [XL-1:0] pc,
                                input logic pw, input logic [3:0] pn);
        obs_t o;
        o.we = we; o.addr = a; o.wdata = d; o.stat = st;
        o.redir = rd; o.pc = pc; o.pwe = pw; o.pn = pn;
        return o;
    endfunction

    task automatic push(input int c, input obs_t o);
        item_t it;
        it.cyc = c;
        it.o   = o;
        sb.push_back(it);
    endtask

    always @(negedge clk) begin
        obs_t  obs;
        item_t it;
        logic  exp_stall;
        if (mon_en) begin
            obs = mk(csr_we, csr_waddr, csr_wdata,
                     {stat_trap_m, stat_trap_s, stat_ret_m, stat_ret_s},
                     redirect, pc_target, priv_we, priv_next);
            exp_stall = (cyc >= st_from) && (cyc <= st_to);
            n_cmp++;
            if (stall !== exp_stall) begin
                n_bad++;
                $display("FAIL stall cyc=%0d got=%b want=%b", cyc, stall, exp_stall);
            end
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missing_output cyc=%0d got=none want=%h", sb[0].cyc, sb[0].o);
                void'(sb.pop_front());
            end
            if (obs !== '0) begin
                n_cmp++;
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    n_bad++;
                    $display("FAIL unexpected_output cyc=%0d got=%h want=0", cyc, obs);
                end else begin
                    it = sb.pop_front();
                    if (obs !== it.o) begin
                        n_bad++;
                        $display("FAIL output cyc=%0d got=%h want=%h", cyc, obs, it.o);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Exception sequence; inj = offset where a stray exc_target_s is raised,
    // rst_at = offset where rst is pulsed (0 = none). pc_t/pn are hand-computed.
    task automatic run_exc(input bit m, input logic [3:0] p, input logic [XL-1:0] cause,
                           input logic [XL-1:0] pc, input logic [XL-1:0] tval,
                           input logic [XL-1:0] tvec, input logic [XL-1:0] pc_t,
                           input logic [3:0] pn, input int inj, input int rst_at,
                           input bit with_mret);
        int c;
        int last;
        c = cyc;
        last = (rst_at != 0) ? rst_at : 5;
        priv = p; exc_target_m = m; exc_target_s = ~m; mret = with_mret;
        exc_cause = cause; exc_pc = pc; exc_tval = tval;
        mtvec = m ? tvec : 64'h5555_5555_5555_5557;
        stvec = m ? 64'hAAAA_AAAA_AAAA_AAAB : tvec;
        mepc = 64'h0BAD_0000; mpp = 2'b11;
        if (last >= 1) push(c + 1, mk(1'b1, m ? 12'h341 : 12'h141, pc, 4'b0, 1'b0, '0, 1'b0, 4'b0));
        if (last >= 2) push(c + 2, mk(1'b1, m ? 12'h342 : 12'h142, cause, 4'b0, 1'b0, '0, 1'b0, 4'b0));
        if (last >= 3) push(c + 3, mk(1'b1, m ? 12'h343 : 12'h143, tval, 4'b0, 1'b0, '0, 1'b0, 4'b0));
        if (last >= 4) push(c + 4, mk(1'b0, 12'h0, '0, m ? 4'b1000 : 4'b0100, 1'b0, '0, 1'b0, 4'b0));
        if (last >= 5) push(c + 5, mk(1'b0, 12'h0, '0, 4'b0, 1'b1, pc_t, 1'b1, pn));
        st_from = c;
        st_to   = c + last;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exc_target_m = 1'b0;
            mret         = 1'b0;
            exc_target_s = (k == inj);
            if (k == inj) begin
                exc_cause = 64'd99; exc_pc = 64'hFFFF_0000; exc_tval = 64'h1;
            end
            rst = (rst_at != 0) && (k == rst_at);
            if (rst_at != 0 && k > rst_at) break;
        end
        tick();
        rst = 1'b0;
        exc_target_s = 1'b0;
        tick();
    endtask

    task automatic run_ret(input bit is_m, input logic [3:0] p, input logic [1:0] pp_m,
                           input logic pp_s, input logic [XL-1:0] epc, input bit ok,
                           input logic [3:0] pn);
        int c;
        c = cyc;
        priv = p; mret = is_m; sret = ~is_m; mpp = pp_m; spp = pp_s;
        mepc = is_m ? epc : 64'h7777;
        sepc = is_m ? 64'h6666 : epc;
        if (ok) begin
            push(c + 1, mk(1'b0, 12'h0, '0, is_m ? 4'b0010 : 4'b0001, 1'b1, epc, 1'b1, pn));
            st_from = c;
            st_to   = c + 1;
        end
        tick();
        mret = 1'b0;
        sret = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; priv = 4'b1000;
        exc_target_m = 1'b0; exc_target_s = 1'b0;
        exc_cause = '0; exc_pc = '0; exc_tval = '0;
        mret = 1'b0; sret = 1'b0;
        mtvec = '0; stvec = '0; mepc = '0; sepc = '0; mpp = 2'b00; spp = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        run_exc(1'b1, 4'b0001, 64'd2, 64'h8000_0100, 64'hDEAD, 64'h8000_0003,
                64'h8000_0000, 4'b1000, 0, 0, 1'b0);
        run_exc(1'b0, 4'b0010, 64'd13, 64'h4000_0200, 64'hBEEF, 64'hFFFF_0000,
                64'hFFFF_0000, 4'b0010, 0, 0, 1'b0);
        run_ret(1'b1, 4'b1000, 2'b01, 1'b0, 64'h1234, 1'b1, 4'b0010);
        run_ret(1'b1, 4'b1000, 2'b10, 1'b0, 64'h1234, 1'b1, 4'b0001);
        run_ret(1'b1, 4'b1000, 2'b11, 1'b0, 64'h2000, 1'b1, 4'b1000);
        run_ret(1'b1, 4'b1000, 2'b00, 1'b0, 64'h2004, 1'b1, 4'b0001);
        run_ret(1'b0, 4'b0001, 2'b00, 1'b1, 64'h3000, 1'b0, 4'b0000);
        run_ret(1'b1, 4'b0010, 2'b11, 1'b0, 64'h3004, 1'b0, 4'b0000);
        run_ret(1'b0, 4'b0010, 2'b00, 1'b0, 64'h4000, 1'b1, 4'b0001);
        run_ret(1'b0, 4'b1000, 2'b00, 1'b1, 64'h4008, 1'b1, 4'b0010);
        run_exc(1'b1, 4'b1000, 64'd3, 64'h100, 64'h0, 64'h8000_1001,
                64'h8000_1000, 4'b1000, 0, 0, 1'b1);
        run_exc(1'b1, 4'b0010, 64'd5, 64'h200, 64'h44, 64'hC002,
                64'hC000, 4'b1000, 2, 0, 1'b0);
        run_exc(1'b0, 4'b0001, 64'd8, 64'h300, 64'h55, 64'h9000,
                64'h9000, 4'b0010, 0, 3, 1'b0);
        run_exc(1'b0, 4'b0001, 64'd15, 64'h340, 64'h66, 64'hA00F,
                64'hA00C, 4'b0010, 0, 0, 1'b0);

        repeat (3) tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
